// File: rtl/wino_pkg.sv
// wino_pkg: shared constants, A^T coefficients and wide saturate/round helpers
package wino_pkg;
    localparam int TILE_IN  = 4;
    localparam int TILE_OUT = 2;
    localparam int MAXW     = 64;
    typedef logic signed [MAXW-1:0] wide_t;
    localparam logic signed [1:0] AT [TILE_OUT][TILE_IN] = '{
        '{2'sd1, 2'sd1, 2'sd1, 2'sd0},
        '{2'sd0, 2'sd1, -2'sd1, -2'sd1}
    };
    function automatic wide_t sat(input wide_t v, input int w);
        wide_t hi, lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        return v > hi ? hi : v < lo ? lo : v;
    endfunction
    // round half up before the arithmetic shift
    function automatic wide_t rshift_round(input wide_t v, input int sh);
        if (sh == 0) return v;
        return (v + (wide_t'(1) <<< (sh - 1))) >>> sh;
    endfunction
endpackage

// File: rtl/wino_at_1d.sv
// wino_at_1d: 1-D A^T transform, 4 inputs to (v0+v1+v2, v1-v2-v3) with 2 bits of growth
module wino_at_1d
    import wino_pkg::*;
#(
    parameter int IW = 32
) (
    input  logic signed [IW-1:0] v [TILE_IN],
    output logic signed [IW+1:0] y [TILE_OUT]
);
    always_comb begin
        for (int i = 0; i < TILE_OUT; i++) begin
            y[i] = '0;
            for (int j = 0; j < TILE_IN; j++)
                y[i] = AT[i][j] == 2'sd1 ? y[i] + (IW+2)'(v[j]) :
                       AT[i][j] == -2'sd1 ? y[i] - (IW+2)'(v[j]) : y[i];
        end
    end
endmodule

// File: rtl/winograd_output_transform_acc.sv
// winograd_output_transform_acc: accumulates 4x4 M tiles over channels, then
// computes Y = A^T*Macc*A with rounding shift, optional ReLU and saturation.
module winograd_output_transform_acc
    import wino_pkg::*;
#(
    parameter int W     = 16,
    parameter int ACC_W = 32,
    parameter int OW    = 16,
    parameter int SHIFT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_last,
    input  logic [16*W-1:0] in_m,
    input  logic            relu_en,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4*OW-1:0] out_y,
    output logic            acc_ovf
);
    localparam int TW = ACC_W + 2;
    localparam int YW = ACC_W + 4;

    logic signed [ACC_W-1:0] acc     [16];
    logic signed [ACC_W-1:0] acc_nxt [16];
    logic [15:0]             ovf;
    logic signed [W-1:0]     m_el;
    wide_t                   sum;
    wide_t                   rs;
    logic                    first, v1, relu1, in_fire, s1_load, s2_load;
    logic signed [ACC_W-1:0] col   [TILE_IN][TILE_IN];
    logic signed [TW-1:0]    t_col [TILE_IN][TILE_OUT];
    logic signed [TW-1:0]    t1    [TILE_OUT][TILE_IN];
    logic signed [YW-1:0]    y_row [TILE_OUT][TILE_OUT];
    logic [4*OW-1:0]         y_nxt;

    assign s2_load  = v1 && (!out_valid || out_ready);
    assign s1_load  = !v1 || s2_load;
    assign in_ready = s1_load;
    assign in_fire  = in_valid && in_ready;

    // the first tile of a sum replaces the stale accumulator contents
    always_comb begin
        m_el = '0;
        sum  = '0;
        ovf  = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                m_el = signed'(in_m[(4*r+c)*W +: W]);
                sum = first ? wide_t'(m_el) : wide_t'(acc[4*r+c]) + wide_t'(m_el);
                acc_nxt[4*r+c] = ACC_W'(sat(sum, ACC_W));
                ovf[4*r+c] = sat(sum, ACC_W) != sum;
                col[c][r] = acc_nxt[4*r+c];
            end
    end

    genvar c, i;
    generate
        for (c = 0; c < TILE_IN; c++) begin : g_col
            wino_at_1d #(.IW(ACC_W)) u_col (.v(col[c]), .y(t_col[c]));
        end
        for (i = 0; i < TILE_OUT; i++) begin : g_row
            wino_at_1d #(.IW(TW)) u_row (.v(t1[i]), .y(y_row[i]));
        end
    endgenerate

    always_comb begin
        y_nxt = '0;
        rs    = '0;
        for (int r = 0; r < TILE_OUT; r++)
            for (int k = 0; k < TILE_OUT; k++) begin
                rs = rshift_round(wide_t'(y_row[r][k]), SHIFT);
                rs = relu1 && rs[MAXW-1] ? '0 : rs;
                y_nxt[(2*r+k)*OW +: OW] = OW'(sat(rs, OW));
            end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            first     <= 1'b1;
            v1        <= 1'b0;
            out_valid <= 1'b0;
            out_y     <= '0;
            acc_ovf   <= 1'b0;
            for (int k = 0; k < 16; k++) acc[k] <= '0;
        end else begin
            if (in_fire) begin
                acc_ovf <= acc_ovf | (|ovf);
                first   <= in_last;
                if (!in_last)
                    for (int k = 0; k < 16; k++) acc[k] <= acc_nxt[k];
            end
            if (s1_load) begin
                v1    <= in_fire && in_last;
                relu1 <= relu_en;
                for (int r = 0; r < TILE_OUT; r++)
                    for (int k = 0; k < TILE_IN; k++) t1[r][k] <= t_col[k][r];
            end
            if (s2_load) out_y <= y_nxt;
            if (!out_valid || out_ready) out_valid <= v1;
        end
    end
endmodule

// File: tb/tb_winograd_output_transform_acc.sv
// tb_winograd_output_transform_acc: two parameterisations driven in lockstep,
// scoreboard queues filled from a matrix-level reference model.
module tb_winograd_output_transform_acc;
    localparam int W  = 16;
    localparam int OW = 16;

    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    logic            in_valid = 0, in_last = 0, relu_en = 0, out_ready = 1;
    logic [16*W-1:0] in_m = '0;
    logic            in_ready0, in_ready1, out_valid0, out_valid1, acc_ovf0, acc_ovf1;
    logic [4*OW-1:0] out_y0, out_y1;

    winograd_output_transform_acc #(.W(W), .ACC_W(32), .OW(OW), .SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_last(in_last),
        .in_m(in_m), .relu_en(relu_en), .out_valid(out_valid0), .out_ready(out_ready),
        .out_y(out_y0), .acc_ovf(acc_ovf0));
    winograd_output_transform_acc #(.W(W), .ACC_W(17), .OW(OW), .SHIFT(2)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_last(in_last),
        .in_m(in_m), .relu_en(relu_en), .out_valid(out_valid1), .out_ready(out_ready),
        .out_y(out_y1), .acc_ovf(acc_ovf1));

    int          n_checks = 0, n_fail = 0;
    logic [63:0] expq0[$], expq1[$];
    longint      macc [2][16];
    bit          first [2] = '{1, 1};
    bit          ovf_e [2] = '{0, 0};
    int          accw  [2] = '{32, 17};
    int          shf   [2] = '{0, 2};
    bit          prev_stall [2] = '{0, 0};
    logic [63:0] prev_y [2];
    bit          rand_bp = 0, hold = 0, fork_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic longint clip(input longint v, input int w);
        longint hi, lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        return v > hi ? hi : v < lo ? lo : v;
    endfunction

    // Y = A^T * Macc * A evaluated as a plain double sum
    function automatic logic [63:0] out_tile(input int d, input bit relu);
        int a [2][4] = '{'{1, 1, 1, 0}, '{0, 1, -1, -1}};
        logic [63:0] res;
        longint y;
        res = '0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                y = 0;
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        y += longint'(a[i][r] * a[j][c]) * macc[d][4*r+c];
                if (shf[d] > 0) y = (y + (longint'(1) <<< (shf[d] - 1))) >>> shf[d];
                if (relu && y < 0) y = 0;
                y = clip(y, OW);
                res[(2*i+j)*OW +: OW] = y[OW-1:0];
            end
        return res;
    endfunction

    task automatic model_fire(input logic [16*W-1:0] m, input bit last, input bit relu);
        logic signed [W-1:0] e;
        longint s, cl;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 16; k++) begin
                e = m[k*W +: W];
                if (first[d]) macc[d][k] = longint'(e);
                else begin
                    s  = macc[d][k] + longint'(e);
                    cl = clip(s, accw[d]);
                    if (cl != s) ovf_e[d] = 1;
                    macc[d][k] = cl;
                end
            end
            first[d] = 0;
            if (last) begin
                if (d == 0) expq0.push_back(out_tile(0, relu));
                else expq1.push_back(out_tile(1, relu));
                first[d] = 1;
            end
        end
    endtask

    task automatic send(input logic [16*W-1:0] m, input bit last, input bit relu);
        int waited = 0;
        @(negedge clk);
        in_valid = 1; in_m = m; in_last = last; relu_en = relu;
        #1;
        while (!in_ready0 && waited < 200) begin
            @(negedge clk); #1; waited++;
        end
        if (!in_ready0) begin
            check("in_ready_timeout", 0, 1);
            in_valid = 0;
            return;
        end
        check("ready_match", in_ready1, in_ready0);
        model_fire(m, last, relu);
        @(posedge clk);
        #1 in_valid = 0;
        check("acc_ovf0", acc_ovf0, ovf_e[0]);
        check("acc_ovf1", acc_ovf1, ovf_e[1]);
    endtask

    task automatic mon(input int d, input logic v, input logic [63:0] y);
        logic [63:0] e;
        if (prev_stall[d]) begin
            check($sformatf("hold_valid%0d", d), v, 1);
            check($sformatf("hold_y%0d", d), y, prev_y[d]);
        end
        if (v && out_ready) begin
            if ((d == 0 && expq0.size() == 0) || (d == 1 && expq1.size() == 0)) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_out%0d: got %h expected none", d, y);
            end else begin
                if (d == 0) e = expq0.pop_front();
                else e = expq1.pop_front();
                check($sformatf("out_y%0d", d), y, e);
            end
        end
        prev_stall[d] = v && !out_ready;
        prev_y[d] = y;
    endtask

    always @(negedge clk) begin
        out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : !hold;
        #2;
        if (!rst) begin
            mon(0, out_valid0, out_y0);
            mon(1, out_valid1, out_y1);
        end
    end

    function automatic logic [16*W-1:0] fill(input logic [W-1:0] v);
        logic [16*W-1:0] t;
        for (int k = 0; k < 16; k++) t[k*W +: W] = v;
        return t;
    endfunction

    function automatic logic [16*W-1:0] rnd_tile(input int lim);
        logic [16*W-1:0] t;
        int v;
        for (int k = 0; k < 16; k++) begin
            v = int'($urandom_range(0, 2 * lim)) - lim;
            t[k*W +: W] = v[W-1:0];
        end
        return t;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1; in_valid = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        first = '{1, 1}; ovf_e = '{0, 0}; prev_stall = '{0, 0};
        expq0.delete(); expq1.delete();
    endtask

    task automatic drain();
        int n = 0;
        while ((expq0.size() != 0 || expq1.size() != 0) && n < 500) begin
            @(negedge clk); n++;
        end
        check("drain0", expq0.size(), 0);
        check("drain1", expq1.size(), 0);
    endtask

    initial begin
        logic [16*W-1:0] t;
        int nch;
        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        check("rst_out_valid", out_valid0, 0);
        check("rst_out_y", out_y0, 0);
        check("rst_acc_ovf", acc_ovf0, 0);
        check("rst_in_ready", in_ready0, 1);

        send(fill(16'd1), 1, 0);
        @(negedge clk); #1 check("lat_e1", out_valid0, 0);
        @(negedge clk); #1 check("lat_e2", out_valid0, 1);
        check("lat_e2_b", out_valid1, 1);

        for (int k = 0; k < 16; k++) t[k*W +: W] = 16'(k);
        for (int n = 0; n < 3; n++) send(t, n == 2, 0);

        t = '0; t[W-1:0] = 16'hFFFB;
        send(t, 1, 1);
        t[W-1:0] = 16'd7;
        send(t, 1, 0);
        drain();

        hold = 1;
        fork
            begin
                for (int n = 0; n < 4; n++) send(rnd_tile(3000), 1, 1'($urandom_range(0, 1)));
                fork_done = 1;
            end
        join_none
        repeat (5) @(negedge clk);
        #1 check("stall_in_ready", in_ready0, 0);
        hold = 0;
        wait (fork_done);
        drain();

        rand_bp = 1;
        for (int n = 0; n < 30; n++) begin
            nch = $urandom_range(1, 4);
            for (int ch = 0; ch < nch; ch++) send(rnd_tile(3000), ch == nch - 1, 1'($urandom_range(0, 1)));
        end
        rand_bp = 0;
        drain();

        for (int n = 0; n < 4; n++) send(fill(16'h7FFF), n == 3, 0);
        send(fill(16'd2), 1, 0);
        drain();
        check("ovf_sticky", acc_ovf1, 1);

        send(rnd_tile(3000), 0, 0);
        send(rnd_tile(3000), 0, 0);
        do_reset();
        #1;
        check("mid_rst_valid", out_valid0, 0);
        check("mid_rst_ovf", acc_ovf1, 0);
        repeat (4) @(negedge clk);
        send(fill(16'd1), 1, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
